// File: rtl/prog_loader.sv
// prog_loader: streams a program into instruction memory, verifies a
// modular checksum, and releases the core from reset on a good load.
module prog_loader #(
    parameter int AW        = 12,
    parameter int IW        = 9,
    parameter int MAX_WORDS = 4096
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    input  logic [IW-1:0] in_word,
    input  logic          in_last,
    output logic          in_ready,
    output logic          imem_wen,
    output logic [AW-1:0] imem_addr,
    output logic [IW-1:0] imem_wdat,
    output logic          core_reset,
    output logic          load_done,
    output logic          err
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        RUN,
        ERROR
    } state_t;

    localparam logic [AW:0] LAST_IDX = (AW+1)'(MAX_WORDS - 1);

    state_t        state;
    state_t        state_nx;
    logic [AW:0]   cnt;
    logic [AW:0]   cnt_nx;
    logic [IW-1:0] sum;
    logic [IW-1:0] sum_nx;
    logic          wen_nx;
    logic [AW-1:0] addr_nx;
    logic [IW-1:0] wdat_nx;
    logic          xfer;

    assign in_ready = (state == LOAD) || (state == CHECK);
    assign xfer     = in_valid && in_ready;

    // Next-state, counters and write-port values; start overrides everything.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        sum_nx   = sum;
        wen_nx   = 1'b0;
        addr_nx  = imem_addr;
        wdat_nx  = imem_wdat;
        if (start) begin
            state_nx = LOAD;
            cnt_nx   = '0;
            sum_nx   = '0;
        end else begin
            unique case (state)
                LOAD: begin
                    if (xfer) begin
                        wen_nx  = 1'b1;
                        addr_nx = cnt[AW-1:0];
                        wdat_nx = in_word;
                        cnt_nx  = cnt + 1'b1;
                        sum_nx  = sum + in_word;
                        if (in_last) begin
                            state_nx = CHECK;
                        end else if (cnt == LAST_IDX) begin
                            state_nx = ERROR;
                        end
                    end
                end
                CHECK: begin
                    if (xfer) begin
                        state_nx = (in_word == sum) ? RUN : ERROR;
                    end
                end
                default: begin
                    state_nx = state;
                end
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            sum        <= '0;
            imem_wen   <= 1'b0;
            imem_addr  <= '0;
            imem_wdat  <= '0;
            core_reset <= 1'b1;
            load_done  <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            sum        <= sum_nx;
            imem_wen   <= wen_nx;
            imem_addr  <= addr_nx;
            imem_wdat  <= wdat_nx;
            core_reset <= (state_nx != RUN);
            load_done  <= (state_nx == RUN);
            err        <= (state_nx == ERROR);
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: table-driven, hand-written and random loads checked
// against a transaction-level model of the loader.
module tb_prog_loader;

    localparam int AW  = 12;
    localparam int IW  = 9;
    localparam int MAX = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [IW-1:0] in_word = '0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic          imem_wen;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_wdat;
    logic          core_reset;
    logic          load_done;
    logic          err;

    int checks = 0;
    int errors = 0;

    logic [AW+IW-1:0] wq[$];

    typedef struct {
        int                 n;
        logic [4:0][IW-1:0] w;
        logic [4:0][3:0]    g;
        bit                 use_last;
        logic [IW-1:0]      chk;
        bit                 exp_ok;
        int                 exp_wr;
    } vec_t;

    vec_t vecs[6];

    prog_loader #(.AW(AW), .IW(IW), .MAX_WORDS(MAX)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .in_valid(in_valid),
        .in_word(in_word),
        .in_last(in_last),
        .in_ready(in_ready),
        .imem_wen(imem_wen),
        .imem_addr(imem_addr),
        .imem_wdat(imem_wdat),
        .core_reset(core_reset),
        .load_done(load_done),
        .err(err)
    );

    always #5 clk = ~clk;

    // Capture every memory write seen on the write port.
    always @(negedge clk) begin
        if (imem_wen) wq.push_back({imem_addr, imem_wdat});
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic xfer(input logic [IW-1:0] w, input logic last,
                        output bit ok);
        int t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        ok = in_ready;
        if (ok) begin
            in_valid = 1'b1;
            in_word  = w;
            in_last  = last;
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic do_load(input vec_t v, input bit do_start);
        bit ok;
        int nsend;
        wq.delete();
        if (do_start) pulse_start();
        nsend = v.use_last ? v.n : ((v.n > MAX) ? MAX : v.n);
        for (int i = 0; i < nsend; i++) begin
            idle(int'(v.g[i]));
            xfer(v.w[i], v.use_last && (i == v.n - 1), ok);
            if (!ok) chk("ready_timeout", 0, 1);
        end
        if (v.use_last) begin
            xfer(v.chk, 1'b0, ok);
            if (!ok) chk("chk_timeout", 0, 1);
        end else begin
            in_valid = 1'b1;
            in_word  = v.w[MAX];
            idle(2);
            in_valid = 1'b0;
        end
        chk("load_done", int'(load_done), int'(v.exp_ok));
        chk("core_reset", int'(core_reset), int'(!v.exp_ok));
        chk("err", int'(err), int'(!v.exp_ok));
        chk("in_ready_end", int'(in_ready), 0);
        idle(1);
        chk("nwrites", wq.size(), v.exp_wr);
        for (int i = 0; i < wq.size() && i < v.exp_wr; i++) begin
            chk("wr_addr", int'(wq[i][AW+IW-1:IW]), i);
            chk("wr_data", int'(wq[i][IW-1:0]), int'(v.w[i]));
        end
    endtask

    initial begin
        vec_t r;
        bit ok;
        logic [IW-1:0] s;

        vecs[0] = '{3, {9'h0, 9'h0, 9'h1FF, 9'h0A5, 9'h001}, '0,
                    1'b1, 9'h0A5, 1'b1, 3};
        vecs[1] = '{3, {9'h0, 9'h0, 9'h1FF, 9'h0A5, 9'h001}, '0,
                    1'b1, 9'h000, 1'b0, 3};
        vecs[2] = '{1, {9'h0, 9'h0, 9'h0, 9'h0, 9'h007}, '0,
                    1'b1, 9'h007, 1'b1, 1};
        vecs[3] = '{3, {9'h0, 9'h0, 9'h030, 9'h020, 9'h010},
                    {4'd0, 4'd0, 4'd1, 4'd2, 4'd0},
                    1'b1, 9'h060, 1'b1, 3};
        vecs[4] = '{5, {9'h5, 9'h4, 9'h3, 9'h2, 9'h1}, '0,
                    1'b0, 9'h000, 1'b0, 4};
        vecs[5] = '{4, {9'h0, 9'h100, 9'h100, 9'h100, 9'h100}, '0,
                    1'b1, 9'h000, 1'b1, 4};

        idle(2);
        reset = 1'b0;
        chk("rst_wen", int'(imem_wen), 0);
        chk("rst_addr", int'(imem_addr), 0);
        chk("rst_wdat", int'(imem_wdat), 0);
        chk("rst_core_reset", int'(core_reset), 1);
        chk("rst_load_done", int'(load_done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_in_ready", int'(in_ready), 0);

        // Cycle-exact good load: each write lands one cycle after its word.
        pulse_start();
        chk("start_ready", int'(in_ready), 1);
        in_valid = 1'b1;
        in_word  = 9'h001;
        @(negedge clk);
        chk("w0_wen", int'(imem_wen), 1);
        chk("w0_addr", int'(imem_addr), 0);
        chk("w0_data", int'(imem_wdat), 9'h001);
        in_word = 9'h0A5;
        @(negedge clk);
        chk("w1_addr", int'(imem_addr), 1);
        chk("w1_data", int'(imem_wdat), 9'h0A5);
        in_word = 9'h1FF;
        in_last = 1'b1;
        @(negedge clk);
        chk("w2_wen", int'(imem_wen), 1);
        chk("w2_addr", int'(imem_addr), 2);
        chk("w2_data", int'(imem_wdat), 9'h1FF);
        in_word = 9'h0A5;
        in_last = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("ck_wen", int'(imem_wen), 0);
        chk("ck_load_done", int'(load_done), 1);
        chk("ck_core_reset", int'(core_reset), 0);
        chk("ck_err", int'(err), 0);

        for (int i = 0; i < 6; i++) do_load(vecs[i], 1'b1);

        // Reload from RUN clears the core release and the running sum.
        do_load(vecs[0], 1'b1);
        pulse_start();
        chk("reload_core_reset", int'(core_reset), 1);
        chk("reload_load_done", int'(load_done), 0);
        chk("reload_ready", int'(in_ready), 1);
        do_load(vecs[5], 1'b0);

        // Reset mid-load drops the transfer presented with it.
        pulse_start();
        xfer(9'h011, 1'b0, ok);
        xfer(9'h022, 1'b0, ok);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_word  = 9'h055;
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("mid_rst_wen", int'(imem_wen), 0);
        chk("mid_rst_core_reset", int'(core_reset), 1);
        chk("mid_rst_ready", int'(in_ready), 0);
        idle(2);
        chk("idle_ready", int'(in_ready), 0);
        do_load(vecs[2], 1'b1);

        // Random loads against the transaction-level model.
        for (int k = 0; k < 40; k++) begin
            r.use_last = ($urandom_range(0, 5) != 0);
            r.n = r.use_last ? int'($urandom_range(1, MAX)) : MAX + 1;
            s = '0;
            for (int i = 0; i < 5; i++) begin
                r.w[i] = IW'($urandom);
                r.g[i] = 4'($urandom_range(0, 2));
                if (i < r.n && i < MAX) s = s + r.w[i];
            end
            r.chk = $urandom_range(0, 1) ? s :
                    s + IW'($urandom_range(1, 511));
            r.exp_ok = r.use_last && (r.chk == s);
            r.exp_wr = (r.n > MAX) ? MAX : r.n;
            do_load(r, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Streaming instruction-memory writer that fills the 9-bit-wide instruction store the core fetches from, then releases the core. It accepts a valid/ready word stream (machine code followed by a checksum word), writes words to consecutive addresses from 0, checks a modular sum, and holds the core in reset until a good load completes. It sits between the bench/host link and the instruction memory write port, alongside the program counter and fetch path.

## Interface

Parameters:
- AW, 12, instruction address width (matches the PC width)
- IW, 9, instruction word width (matches machine code width)
- MAX_WORDS, 4096, maximum program length in words; must satisfy 1 <= MAX_WORDS <= 2**AW

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to begin or restart a load
- in_valid  in  1  in_word is valid this cycle
- in_word  in  IW  program word, or the checksum word in CHECK
- in_last  in  1  marks the final program word; ignored in CHECK
- in_ready  out  1  loader accepts a word this cycle
- imem_wen  out  1  instruction memory write enable
- imem_addr  out  AW  instruction memory write address
- imem_wdat  out  IW  instruction memory write data
- core_reset  out  1  holds the processor in reset while high
- load_done  out  1  program loaded and verified; core running
- err  out  1  load failed (bad checksum or overflow)

## Operation

- States: IDLE, LOAD, CHECK, RUN, ERROR. A transfer happens when in_valid && in_ready.
- in_ready is a decode of the registered state: 1 in LOAD and CHECK, 0 otherwise.
- All other outputs are registered.
- Internal registers: cnt (AW+1 bits, number of words written) and sum (IW bits, sum of accepted program words mod 2**IW).
- IDLE:
  - core_reset=1, load_done=0, err=0.
  - On start: go to LOAD with cnt=0 and sum=0.
- LOAD, on each transfer:
  - Next cycle: imem_wen=1, imem_addr=cnt[AW-1:0], imem_wdat=in_word.
  - cnt increments by 1; sum becomes sum+in_word, truncated to IW bits.
  - If in_last=1: go to CHECK.
  - Else, if cnt==MAX_WORDS-1 before the increment: the word is still written, then go to ERROR (overflow).
- CHECK:
  - The next transfer is the checksum word. It is never written to memory.
  - If in_word==sum: go to RUN. Otherwise: go to ERROR.
- RUN:
  - core_reset=0, load_done=1.
  - On start: go to LOAD, clear cnt and sum; core_reset=1 and load_done=0 from the next cycle.
- ERROR:
  - err=1, core_reset=1.
  - On start: go to LOAD; err clears the next cycle.
- start while in LOAD or CHECK restarts the load: cnt=0, sum=0, state becomes LOAD.
  - A transfer in the same cycle is discarded, with no write.
- imem_wen is 0 in every cycle not immediately following a LOAD transfer.

## Timing

- Reset (synchronous, one edge):
  - State goes to IDLE; cnt=0, sum=0.
  - Outputs: imem_wen=0, imem_addr=0, imem_wdat=0, core_reset=1, load_done=0, err=0, in_ready=0.
  - Reset takes priority over start and over any transfer.
- Reset mid-LOAD aborts the load: no write is issued for a transfer presented in the reset cycle.
- Write latency: a transfer at edge N produces imem_wen=1 with its address and data during cycle N+1 (one-cycle pulse).
- Back-to-back transfers are supported at one word per cycle. in_valid gaps produce no write and do not advance the address.
- Last-word transfer at edge N: state=CHECK from cycle N+1, and that word's write also occurs in cycle N+1.
- Checksum transfer at edge M: load_done=1 and core_reset=0 (or err=1) from cycle M+1.
- start from IDLE at edge S: in_ready=1 from cycle S+1.
- Minimum load: 1 word with in_last=1, then the checksum; RUN is reached 2 cycles after the first transfer.
- Address wrap is impossible: overflow is caught at MAX_WORDS.

## Test plan

- Good load: reset, start, stream 0x001, 0x0A5, 0x1FF (last), then checksum 0x0A5.
  - Required: writes 0x001@0, 0x0A5@1, 0x1FF@2 on consecutive cycles.
  - Required: load_done=1 and core_reset=0 one cycle after the checksum; err=0.
- Bad checksum: same stream with checksum 0x000.
  - Required: ERROR, err=1, core_reset=1, load_done=0.
  - Then start plus a good 1-word load (0x007, checksum 0x007): err=0, RUN.
- Valid gaps: in_valid pattern 1,0,0,1,0,1(last), then checksum.
  - Required: exactly 3 writes at addresses 0, 1, 2; no write in gap cycles.
- Overflow with MAX_WORDS=4: send 5 words, none with in_last.
  - Required: addresses 0-3 written, ERROR after the 4th transfer, in_ready=0, 5th word never written.
- Reset mid-load: after 2 accepted words, assert reset for one cycle with a transfer presented.
  - Required: no write, IDLE, core_reset=1.
  - Next start: first write lands at address 0.
- Reload from RUN: start while in RUN.
  - Required: core_reset=1 and load_done=0 the next cycle; new load begins at address 0 with sum reset.
